// File: rtl/mu0_mem_if.sv
// MU0 memory interface: IDLE/REQ/DONE handshake between the MU0 core and a slow memory port.
// Optional REQ timeout with sticky Bus_err is enabled by defining MU0_MEMIF_TIMEOUT_EN.
module mu0_mem_if #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Data_out,
  output logic [DATA_W-1:0] Data_in,
  output logic              Ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       Access_cnt,
  output logic              Bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mu0_mem_if: TIMEOUT must be at least 1");
  end

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic [15:0]         access_cnt_q, access_cnt_d;

`ifdef MU0_MEMIF_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                bus_err_q, bus_err_d;
`endif

  // Next-state and next-output logic for the handshake
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    data_in_d    = data_in_q;
    access_cnt_d = access_cnt_q;
`ifdef MU0_MEMIF_TIMEOUT_EN
    tmo_cnt_d    = '0;
    bus_err_d    = bus_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (Rd || Wr) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = Wr;
          mem_addr_d  = Addr;
          mem_wdata_d = Data_out;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          access_cnt_d = access_cnt_q + 16'd1;
          if (!mem_we_q) begin
            data_in_d = mem_rdata;
          end else begin
            data_in_d = data_in_q;
          end
`ifdef MU0_MEMIF_TIMEOUT_EN
        // An ack on the final allowed cycle still wins over the timeout.
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          access_cnt_d = access_cnt_q + 16'd1;
          bus_err_d    = 1'b1;
          if (!mem_we_q) begin
            data_in_d = '0;
          end else begin
            data_in_d = data_in_q;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`else
        end else begin
          state_d = REQ;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      data_in_q    <= '0;
      access_cnt_q <= 16'd0;
`ifdef MU0_MEMIF_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      data_in_q    <= data_in_d;
      access_cnt_q <= access_cnt_d;
`ifdef MU0_MEMIF_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign Ready      = (state_q == DONE) || ((state_q == IDLE) && !Rd && !Wr);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign Data_in    = data_in_q;
  assign Access_cnt = access_cnt_q;
`ifdef MU0_MEMIF_TIMEOUT_EN
  assign Bus_err    = bus_err_q;
`else
  assign Bus_err    = 1'b0;
`endif

endmodule

// File: doc/mu0_mem_if.md
MU0_MEM_IF -- requirements
Module: mu0_mem_if

Interface
REQ-001 SHALL provide parameter ADDR_W, default 12, address width.
REQ-002 SHALL provide parameter DATA_W, default 16, data width.
REQ-003 SHALL provide parameter TIMEOUT, default 255, max REQ-state cycles awaiting ack (used only under REQ-030).
REQ-004 SHALL have port Clk  input  1  system clock; one clock, all state on rising edge.
REQ-005 SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port Rd  input  1  memory read request from MU0 control.
REQ-007 SHALL have port Wr  input  1  memory write request from MU0 control.
REQ-008 SHALL have port Addr  input  ADDR_W  access address from MU0 datapath.
REQ-009 SHALL have port Data_out  input  DATA_W  write data from MU0 datapath.
REQ-010 SHALL have port Data_in  output  DATA_W  read data to MU0 datapath, registered.
REQ-011 SHALL have port Ready  output  1  high = CPU may advance; low = stall.
REQ-012 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W: registered memory-side request.
REQ-013 SHALL have ports mem_rdata input DATA_W, mem_ack input 1: memory-side response.
REQ-014 SHALL have port Access_cnt  output  16  count of completed transfers.
REQ-015 SHALL have port Bus_err  output  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DONE.
REQ-017 IDLE with Rd or Wr high SHALL capture Addr->mem_addr, Data_out->mem_wdata, Wr->mem_we, and go to REQ.
REQ-018 Rd and Wr both high in IDLE SHALL be handled as a write (Wr priority).
REQ-019 mem_req SHALL be 1 exactly while in REQ; mem_addr/mem_we/mem_wdata SHALL stay stable throughout REQ.
REQ-020 REQ with mem_ack high SHALL go to DONE; on a read, mem_rdata SHALL be latched into Data_in on that edge; a write SHALL leave Data_in unchanged.
REQ-021 mem_ack outside REQ SHALL be ignored.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; Access_cnt SHALL increment on entry to DONE, wrapping 16'hFFFF->16'h0000.
REQ-023 Ready SHALL be combinational: 1 in DONE, or in IDLE with Rd=Wr=0; else 0.
REQ-024 Minimum latency: request sampled edge 0, mem_req high cycle 1, ack in cycle 1 -> Ready high cycle 2 (3 cycles request-to-Ready).
REQ-025 Rd/Wr still high in the IDLE cycle after DONE SHALL start a new transfer.
REQ-026 Rd/Wr changes during REQ or DONE SHALL be ignored.

Reset
REQ-027 Reset low at a rising edge SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Data_in=0, Access_cnt=0, Bus_err=0, timeout counter=0.
REQ-028 Reset mid-transfer SHALL abandon it; no Access_cnt increment; mem_req low from the following cycle.
REQ-029 Rd/Wr SHALL be ignored in any cycle with Reset low.

Configuration
REQ-030 With macro MU0_MEMIF_TIMEOUT_EN defined: a counter SHALL count REQ cycles; on reaching TIMEOUT with no ack, go to DONE, set Data_in=0 on reads, set Bus_err=1 (sticky until reset), increment Access_cnt.
REQ-031 Without MU0_MEMIF_TIMEOUT_EN: REQ SHALL wait indefinitely for mem_ack; Bus_err SHALL be constant 0; TIMEOUT unused.

Verification
REQ-032 Read, zero-wait: Rd=1, Addr=12'h005, ack in first REQ cycle with mem_rdata=16'h1234 -> mem_req 1 cycle, Data_in=16'h1234, Ready high cycle 2, Access_cnt=1.
REQ-033 Write, 3 wait cycles: Wr=1, Addr=12'hFFF, Data_out=16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF stable 4 REQ cycles, Ready low throughout, one-cycle Ready pulse after ack.
REQ-034 Rd=Wr=1, Addr=12'h010 -> mem_we=1; Data_in unchanged after completion.
REQ-035 Reset low during REQ -> next cycle IDLE, mem_req=0, Access_cnt=0, Ready=1 with Rd=Wr=0.
REQ-036 Macro defined, TIMEOUT=4, no ack on read -> DONE after 4 REQ cycles, Data_in=0, Bus_err=1 stays set through next good transfer; macro undefined -> mem_req held high 300 cycles, Bus_err=0.
REQ-037 Preload Access_cnt to 16'hFFFF via 65535 transfers (or force), one more transfer -> Access_cnt=16'h0000.
